// File: rtl/arvi_bus_pkg.sv
// -----------------------------------------------------------------------------
// arvi_bus_pkg
// Shared definitions for the simple request/ack memory bus.
//   BUS_AW / BUS_DW / BUS_BEW : byte-address, data and byte-enable widths
//   WAIT_CNT_W                : width of the wait-state counter
//   bus_state_e               : slave FSM state encoding (also exported on the
//                               slave's debug output)
// -----------------------------------------------------------------------------
package arvi_bus_pkg;

    localparam int BUS_AW     = 32;
    localparam int BUS_DW     = 32;
    localparam int BUS_BEW    = BUS_DW / 8;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_mem_array.sv
// -----------------------------------------------------------------------------
// bus_mem_array
// Single-port word memory with byte-lane writes and a registered read port.
//   clk    : rising-edge clock
//   rst_n  : async active-low reset, clears only the read-data register
//   en     : access strobe for this edge
//   we     : 1 = write lanes selected by be, 0 = read whole word
//   addr   : word index
//   wdata  : write data
//   be     : byte-lane enables, bit n covers wdata[8n+7:8n]
//   clr    : zero the read-data register (faulted access)
//   rdata  : read data, updated only by a read, otherwise held
// The storage itself has no reset so its contents survive a bus reset.
// -----------------------------------------------------------------------------
module bus_mem_array
    import arvi_bus_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [BUS_DW-1:0] wdata,
    input  logic [BUS_BEW-1:0] be,
    input  logic              clr,
    output logic [BUS_DW-1:0] rdata
);

    logic [BUS_DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BUS_BEW; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Writes leave rdata alone; it only tracks the most recent read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end else if (clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/bus_mem_slave.sv
// -----------------------------------------------------------------------------
// bus_mem_slave
// Memory-backed bus slave with a configurable number of wait states.
//   i_clk      : rising-edge clock
//   i_rst      : async active-low reset
//   i_bus_en   : request valid
//   i_wr_en    : 1 = write, 0 = read
//   i_addr     : byte address (bits [1:0] ignored)
//   i_wr_data  : write data
//   i_byte_en  : write byte lanes
//   o_ack      : one-cycle completion pulse
//   o_rd_data  : read data, valid while o_ack is high, held until next read
//   o_state    : FSM state (debug)
//   o_err      : access fault, only with ARVI_BUS_RANGE_CHECK_EN defined
//
// Handshake: the master raises i_bus_en with a stable request and holds it
// until it sees o_ack. The request is sampled once, at the accepting edge in
// IDLE; inputs are ignored while in WAIT/ACK. If i_bus_en is still high in the
// IDLE cycle following ACK it is taken as a fresh request.
//
// Build option ARVI_BUS_RANGE_CHECK_EN: addresses outside the window
// [BASE_ADDR, BASE_ADDR + MEM_WORDS*4) complete with o_err=1 and zero read
// data and never write. Without it, addresses alias modulo MEM_WORDS.
// -----------------------------------------------------------------------------
module bus_mem_slave
    import arvi_bus_pkg::*;
#(
    parameter int               MEM_WORDS   = 1024,
    parameter logic [BUS_AW-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int               WAIT_CYCLES = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_bus_en,
    input  logic               i_wr_en,
    input  logic [BUS_AW-1:0]  i_addr,
    input  logic [BUS_DW-1:0]  i_wr_data,
    input  logic [BUS_BEW-1:0] i_byte_en,
    output logic               o_ack,
    output logic [BUS_DW-1:0]  o_rd_data,
    output bus_state_e         o_state
`ifdef ARVI_BUS_RANGE_CHECK_EN
    ,
    output logic               o_err
`endif
);

    localparam int                AW        = $clog2(MEM_WORDS);
    localparam logic [BUS_AW-1:0] SPAN      = BUS_AW'(MEM_WORDS * 4);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    bus_state_e              state, state_d;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_d;
    logic                    lat_wr, lat_wr_d;
    logic [BUS_AW-1:0]       lat_addr, lat_addr_d;
    logic [BUS_DW-1:0]       lat_wdata, lat_wdata_d;
    logic [BUS_BEW-1:0]      lat_be, lat_be_d;
    logic                    ack_q;

    // Access strobe and the request it uses. With zero wait states the
    // access happens on the accepting edge, so the live inputs are used.
    logic                    access;
    logic                    acc_wr;
    logic [BUS_AW-1:0]       acc_addr;
    logic [BUS_DW-1:0]       acc_wdata;
    logic [BUS_BEW-1:0]      acc_be;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_wr_d    = lat_wr;
        lat_addr_d  = lat_addr;
        lat_wdata_d = lat_wdata;
        lat_be_d    = lat_be;
        access      = 1'b0;
        acc_wr      = lat_wr;
        acc_addr    = lat_addr;
        acc_wdata   = lat_wdata;
        acc_be      = lat_be;

        case (state)
            ST_IDLE: begin
                acc_wr    = i_wr_en;
                acc_addr  = i_addr;
                acc_wdata = i_wr_data;
                acc_be    = i_byte_en;
                if (i_bus_en) begin
                    lat_wr_d    = i_wr_en;
                    lat_addr_d  = i_addr;
                    lat_wdata_d = i_wr_data;
                    lat_be_d    = i_byte_en;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        access  = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    access  = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            ack_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_wr    <= lat_wr_d;
            lat_addr  <= lat_addr_d;
            lat_wdata <= lat_wdata_d;
            lat_be    <= lat_be_d;
            ack_q     <= (state_d == ST_ACK);
        end
    end

    // Word index relative to the window base; the subtraction wraps, so an
    // address below BASE_ADDR lands far above SPAN and fails the range test.
    logic [BUS_AW-1:0] offset;
    logic [AW-1:0]     word_idx;
    logic              in_range;
    logic              unused_offset_bits;

    assign offset             = acc_addr - BASE_ADDR;
    assign word_idx           = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[BUS_AW-1:AW+2], offset[1:0]};

`ifdef ARVI_BUS_RANGE_CHECK_EN
    logic err_q;

    assign in_range = (offset < SPAN);

    // The ack cycle always directly follows the access edge, so a flag set
    // at that edge is exactly aligned with o_ack.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && !in_range;
        end
    end

    assign o_err = err_q;
`else
    assign in_range = 1'b1;
`endif

    // Memory strobes are qualified with reset so that an edge arriving
    // while reset is held can never commit a write.
    logic mem_en;
    logic mem_clr;

    assign mem_en  = access && i_rst && in_range;
    assign mem_clr = access && i_rst && !in_range;

    bus_mem_array #(
        .WORDS (MEM_WORDS)
    ) u_array (
        .clk   (i_clk),
        .rst_n (i_rst),
        .en    (mem_en),
        .we    (acc_wr),
        .addr  (word_idx),
        .wdata (acc_wdata),
        .be    (acc_be),
        .clr   (mem_clr),
        .rdata (o_rd_data)
    );

    assign o_ack   = ack_q;
    assign o_state = state;

endmodule

// File: tb/tb_bus_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_slave
// Directed bench for bus_mem_slave. Two instances share clock and reset:
// dut0 with no wait states and dut3 with three. Inputs are driven on the
// falling edge and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_mem_slave;
    import arvi_bus_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- dut0 (WAIT_CYCLES = 0) ----------------
    logic        en0, we0, ack0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;
    bus_state_e  st0;

    // ---------------- dut3 (WAIT_CYCLES = 3) ----------------
    logic        en3, we3, ack3;
    logic [31:0] addr3, wd3, rd3;
    logic [3:0]  be3;
    bus_state_e  st3;

`ifdef ARVI_BUS_RANGE_CHECK_EN
    logic err0, err3;
`endif

    bus_mem_slave #(
        .MEM_WORDS   (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (0)
    ) dut0 (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_bus_en  (en0),
        .i_wr_en   (we0),
        .i_addr    (addr0),
        .i_wr_data (wd0),
        .i_byte_en (be0),
        .o_ack     (ack0),
        .o_rd_data (rd0),
        .o_state   (st0)
`ifdef ARVI_BUS_RANGE_CHECK_EN
        ,
        .o_err     (err0)
`endif
    );

    bus_mem_slave #(
        .MEM_WORDS   (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (3)
    ) dut3 (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_bus_en  (en3),
        .i_wr_en   (we3),
        .i_addr    (addr3),
        .i_wr_data (wd3),
        .i_byte_en (be3),
        .o_ack     (ack3),
        .o_rd_data (rd3),
        .o_state   (st3)
`ifdef ARVI_BUS_RANGE_CHECK_EN
        ,
        .o_err     (err3)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive(input int sel, input logic en, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        if (sel == 0) begin
            en0 = en; we0 = we; addr0 = a; wd0 = wd; be0 = b;
        end else begin
            en3 = en; we3 = we; addr3 = a; wd3 = wd; be3 = b;
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? ack0 : ack3;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? rd0 : rd3;
    endfunction

    function automatic logic get_err(input int sel);
`ifdef ARVI_BUS_RANGE_CHECK_EN
        return (sel == 0) ? err0 : err3;
`else
        return (sel == 0) ? 1'b0 : 1'b0;
`endif
    endfunction

    // One complete transaction. Called at a falling edge; returns at a
    // falling edge with the slave back in IDLE. Checks the accept-to-ack
    // latency and that the ack is a single-cycle pulse.
    task automatic bus_access(input int sel, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] b,
                              output logic [31:0] rd, output logic er);
        int lat;
        int exp_lat;
        exp_lat = (sel == 0) ? 1 : 4;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        drive(sel, 1'b1, we, a, wd, b);
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (get_ack(sel)) begin
                lat = i;
                rd  = get_rd(sel);
                er  = get_err(sel);
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check($sformatf("lat_dut%0d_%h", sel, a), 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check($sformatf("ack_pulse_dut%0d", sel), {31'h0, get_ack(sel)}, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic        er;
    logic [3:0]  pat;
    logic [31:0] b2b_rd;
    logic        ack_seen;

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_ack0",   {31'h0, ack0}, 32'h0);
        check("rst_rd0",    rd0, 32'h0);
        check("rst_state0", 32'(st0), 32'(ST_IDLE));
        check("rst_ack3",   {31'h0, ack3}, 32'h0);
        check("rst_rd3",    rd3, 32'h0);
        rst_n = 1'b1;

        // Basic write then read, zero wait states
        bus_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        bus_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("rd_0x10", rd, 32'hDEADBEEF);

        // A write does not disturb the read-data register
        bus_access(0, 1'b1, 32'h14, 32'h55AA55AA, 4'hF, rd, er);
        check("wr_keeps_rd", rd, 32'hDEADBEEF);

        // Byte-lane merge
        bus_access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er);
        bus_access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er);
        bus_access(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        check("be_merge", rd, 32'h11BB33DD);

        // No lanes enabled: acks, no change; low address bits ignored
        bus_access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er);
        bus_access(0, 1'b0, 32'h23, 32'h0, 4'hF, rd, er);
        check("be_none_unaligned", rd, 32'h11BB33DD);

        // Three wait states
        bus_access(3, 1'b1, 32'h10, 32'h01234567, 4'hF, rd, er);
        bus_access(3, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("w3_rd_0x10", rd, 32'h01234567);
        bus_access(3, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, er);

        // Back-to-back: i_bus_en held over two requests
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk); pat[0] = ack0;
        @(negedge clk); pat[1] = ack0;
        @(negedge clk); pat[2] = ack0; b2b_rd = rd0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); pat[3] = ack0;
        check("b2b_ack_pattern", {28'h0, pat}, 32'h5);
        check("b2b_rd", b2b_rd, 32'h55AA55AA);

        // Reset in the middle of a WAIT phase of a write
        drive(3, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("w3_in_wait", 32'(st3), 32'(ST_WAIT));
        #2 rst_n = 1'b0;
        #1;
        check("abort_ack",   {31'h0, ack3}, 32'h0);
        check("abort_rd",    rd3, 32'h0);
        check("abort_state", 32'(st3), 32'(ST_IDLE));
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            ack_seen = ack_seen | ack3;
        end
        check("abort_no_ack", {31'h0, ack_seen}, 32'h0);
        rst_n = 1'b1;
        bus_access(3, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
        check("abort_no_write", rd, 32'h0BADF00D);
        bus_access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("mem_survives_rst", rd, 32'hDEADBEEF);

        // Address beyond the window
        bus_access(0, 1'b1, 32'h0, 32'hCAFE0001, 4'hF, rd, er);
        bus_access(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
`ifdef ARVI_BUS_RANGE_CHECK_EN
        check("oor_err", {31'h0, er}, 32'h1);
        check("oor_rd",  rd, 32'h0);
        bus_access(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        check("inr_err", {31'h0, er}, 32'h0);
        check("inr_rd",  rd, 32'hCAFE0001);
`else
        check("alias_rd", rd, 32'hCAFE0001);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
